// File: rtl/blockram_rr_arbiter_if.sv
// Client-side bundle for the two-port block RAM arbiter.
// master = the client engines, slave = the arbiter.
interface blockram_rr_arbiter_if #(
    parameter int blockLength     = 32,
    parameter int addressBitWidth = 6
);
    logic                       req0;
    logic                       we0;
    logic [addressBitWidth-1:0] addr0;
    logic [blockLength-1:0]     wdata0;
    logic                       gnt0;
    logic                       rvalid0;
    logic [blockLength-1:0]     rdata0;

    logic                       req1;
    logic                       we1;
    logic [addressBitWidth-1:0] addr1;
    logic [blockLength-1:0]     wdata1;
    logic                       gnt1;
    logic                       rvalid1;
    logic [blockLength-1:0]     rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/blockram_rr_arbiter.sv
// Round-robin sharing of one single-port sync-read block RAM between two clients.
// Define BLOCKRAM_CLEAR_ON_RESET_EN to sweep CLEAR_VALUE into every word after reset.
module blockram_rr_arbiter #(
    parameter int                     blockLength     = 32,
    parameter int                     memDepth        = 64,
    parameter int                     addressBitWidth = 6,
    parameter logic [blockLength-1:0] CLEAR_VALUE     = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    blockram_rr_arbiter_if.slave       cl,
    output logic                       mem_we,
    output logic [addressBitWidth-1:0] mem_addr,
    output logic [blockLength-1:0]     mem_din,
    input  logic [blockLength-1:0]     mem_dout,
    output logic                       busy
);

    logic arb_en;
    logic gnt0, gnt1;
    logic ptr_q, ptr_d;          // 1 = port 1 has priority on a tie
    logic rvalid0_q, rvalid0_d;
    logic rvalid1_q, rvalid1_d;

`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_ARB} state_t;

    localparam logic [addressBitWidth-1:0] CLR_LAST = addressBitWidth'(memDepth - 1);

    state_t                     state_q, state_d;
    logic [addressBitWidth-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b0;
        arb_en    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = ST_ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_ARB: arb_en = !reset;
            default: state_d = ST_CLEAR;
        endcase
    end
`else
    logic unused_clear_value;

    // No sweep: CLEAR_VALUE has no effect in this build.
    assign unused_clear_value = ^CLEAR_VALUE;
    assign busy               = 1'b0;
    assign arb_en             = !reset;
`endif

    // Tie goes to the port not granted last; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (cl.req0 && (!cl.req1 || !ptr_q)) gnt0 = 1'b1;
            else if (cl.req1)                    gnt1 = 1'b1;
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cl.addr0;
        mem_din  = cl.wdata0;
`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        if (busy) begin
            mem_we   = !reset;
            mem_addr = clr_cnt_q;
            mem_din  = CLEAR_VALUE;
        end
`endif
        if (gnt1) begin
            mem_we   = cl.we1;
            mem_addr = cl.addr1;
            mem_din  = cl.wdata1;
        end else if (gnt0) begin
            mem_we   = cl.we0;
            mem_addr = cl.addr0;
            mem_din  = cl.wdata0;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        if (gnt0)      ptr_d = 1'b1;
        else if (gnt1) ptr_d = 1'b0;
        rvalid0_d = gnt0 && !cl.we0;
        rvalid1_d = gnt1 && !cl.we1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign cl.gnt0    = gnt0;
    assign cl.gnt1    = gnt1;
    assign cl.rvalid0 = rvalid0_q;
    assign cl.rvalid1 = rvalid1_q;
    // RAM output is shared; each rvalid says whose data it is this cycle.
    assign cl.rdata0  = mem_dout;
    assign cl.rdata1  = mem_dout;

    a_onehot_gnt : assert property (@(posedge clock) !(gnt0 && gnt1));
    a_no_gnt_busy: assert property (@(posedge clock) busy |-> !(gnt0 || gnt1));
    a_rd_ret0    : assert property (@(posedge clock) disable iff (reset)
                                    (gnt0 && !cl.we0) |=> rvalid0_q);
    a_rd_ret1    : assert property (@(posedge clock) disable iff (reset)
                                    (gnt1 && !cl.we1) |=> rvalid1_q);
    a_addr_range : assert property (@(posedge clock)
                                    !mem_we || (int'(mem_addr) < memDepth));

endmodule

// File: tb/tb_blockram_rr_arbiter.sv
// Directed bench for blockram_rr_arbiter with a behavioural sync-read RAM.
// Covers both builds of BLOCKRAM_CLEAR_ON_RESET_EN.
module tb_blockram_rr_arbiter;
    localparam int BL = 32;
    localparam int MD = 64;
    localparam int AW = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    blockram_rr_arbiter_if #(.blockLength(BL), .addressBitWidth(AW)) cl ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BL-1:0] mem_din;
    logic [BL-1:0] mem_dout;
    logic          busy;
    logic [BL-1:0] ram [MD];

    blockram_rr_arbiter #(
        .blockLength(BL), .memDepth(MD), .addressBitWidth(AW), .CLEAR_VALUE('0)
    ) dut (
        .clock(clock), .reset(reset), .cl(cl.slave),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    // "Init file" contents of the RAM.
    initial for (int i = 0; i < MD; i++) ram[i] = 32'hA000_0000 + i;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [BL-1:0] init_val(input int a);
`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        return '0;
`else
        return 32'hA000_0000 + a;
`endif
    endfunction

    task automatic set0(input logic r, input logic w, input int a, input logic [BL-1:0] d);
        cl.req0 = r; cl.we0 = w; cl.addr0 = AW'(a); cl.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input int a, input logic [BL-1:0] d);
        cl.req1 = r; cl.we1 = w; cl.addr1 = AW'(a); cl.wdata1 = d;
    endtask

    task automatic idle;
        set0(0, 0, 0, '0);
        set1(0, 0, 0, '0);
    endtask

    task automatic do_reset;
        @(negedge clock); idle(); reset = 1'b1;
        @(negedge clock); reset = 1'b0; #1;
`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        for (int k = 0; k < 100 && busy; k++) begin @(negedge clock); #1; end
        chk("sweep_done", busy, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        idle();
        // Reset with a read of addr 3 already pending on port 0.
        @(negedge clock); reset = 1'b1; set0(1, 0, 3, '0); #1;
        chk("rst_gnt0", cl.gnt0, 0);
        chk("rst_mem_we", mem_we, 0);
        @(negedge clock); reset = 1'b0; #1;
        chk("rst_rvalid0", cl.rvalid0, 0);
        chk("rst_rvalid1", cl.rvalid1, 0);
`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        for (int k = 0; k < MD; k++) begin
            if (k != 0) begin @(negedge clock); #1; end
            chk("clr_busy", busy, 1);
            chk("clr_we", mem_we, 1);
            chk("clr_addr", mem_addr, k);
            chk("clr_din", mem_din, 0);
            chk("clr_gnt0_held", cl.gnt0, 0);
        end
        @(negedge clock); #1;
        chk("clr_busy_fall", busy, 0);
`else
        chk("nomacro_busy", busy, 0);
`endif
        chk("first_gnt0", cl.gnt0, 1);
        chk("first_addr", mem_addr, 3);
        chk("first_we", mem_we, 0);
        @(negedge clock); idle(); #1;
        chk("first_rvalid0", cl.rvalid0, 1);
        chk("first_rdata0", cl.rdata0, init_val(3));
        chk("first_rvalid1", cl.rvalid1, 0);

        // Write then same-address read on port 0.
        @(negedge clock); set0(1, 1, 5, 32'hDEADBEEF); #1;
        chk("wr_gnt0", cl.gnt0, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 5);
        chk("wr_din", mem_din, 32'hDEADBEEF);
        @(negedge clock); set0(1, 0, 5, '0); #1;
        chk("rd_gnt0", cl.gnt0, 1);
        chk("rd_we", mem_we, 0);
        chk("wr_no_rvalid", cl.rvalid0, 0);
        @(negedge clock); idle(); #1;
        chk("raw_rvalid0", cl.rvalid0, 1);
        chk("raw_rdata0", cl.rdata0, 32'hDEADBEEF);
        chk("raw_rvalid1", cl.rvalid1, 0);
        @(negedge clock); #1;
        chk("raw_rvalid0_drop", cl.rvalid0, 0);

        // Both ports requesting: strict alternation starting with port 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); set0(1, 0, 8 + i, '0); set1(1, 0, 16 + i, '0); #1;
            chk("alt_gnt0", cl.gnt0, (i % 2) == 0);
            chk("alt_gnt1", cl.gnt1, (i % 2) == 1);
            chk("alt_addr", mem_addr, (i % 2) == 0 ? 8 + i : 16 + i);
            if (i > 0) begin
                chk("alt_rvalid0", cl.rvalid0, ((i - 1) % 2) == 0);
                chk("alt_rvalid1", cl.rvalid1, ((i - 1) % 2) == 1);
                if (((i - 1) % 2) == 0) chk("alt_rdata0", cl.rdata0, init_val(8 + i - 1));
                else                    chk("alt_rdata1", cl.rdata1, init_val(16 + i - 1));
            end
        end
        @(negedge clock); idle(); #1;
        chk("alt_last_rvalid1", cl.rvalid1, 1);
        chk("alt_last_rdata1", cl.rdata1, init_val(21));
        chk("alt_last_rvalid0", cl.rvalid0, 0);

        // Port 1 alone, back-to-back; pointer then favours port 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); set1(1, 0, 24 + i, '0); #1;
            chk("b2b_gnt1", cl.gnt1, 1);
            chk("b2b_gnt0", cl.gnt0, 0);
            if (i > 0) begin
                chk("b2b_rvalid1", cl.rvalid1, 1);
                chk("b2b_rdata1", cl.rdata1, init_val(24 + i - 1));
            end
        end
        @(negedge clock); set0(1, 0, 30, '0); set1(1, 0, 31, '0); #1;
        chk("ptr_fav0", cl.gnt0, 1);
        chk("ptr_fav0_n1", cl.gnt1, 0);
        chk("b2b_tail_rdata1", cl.rdata1, init_val(27));
        @(negedge clock); set0(1, 0, 32, '0); #1;
        chk("fair_gnt1", cl.gnt1, 1);
        chk("fair_rvalid0", cl.rvalid0, 1);
        chk("fair_rdata0", cl.rdata0, init_val(30));
        @(negedge clock); idle(); #1;
        chk("idle_gnt0", cl.gnt0, 0);
        chk("idle_gnt1", cl.gnt1, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_rdata1", cl.rdata1, init_val(31));

        // Pointer is held across idle cycles.
        @(negedge clock); set0(1, 1, 40, 32'h1234_5678); #1;
        chk("solo_gnt0", cl.gnt0, 1);
        @(negedge clock); idle(); #1;
        chk("solo_no_rvalid", cl.rvalid0, 0);
        @(negedge clock); set0(1, 0, 40, '0); set1(1, 0, 41, '0); #1;
        chk("ptr_hold_gnt1", cl.gnt1, 1);
        chk("ptr_hold_gnt0", cl.gnt0, 0);

        // Reset returns the pointer to port 0.
        @(negedge clock); idle(); set0(1, 0, 42, '0); #1;
        chk("pre_rst_gnt0", cl.gnt0, 1);
        do_reset();
        @(negedge clock); set0(1, 0, 43, '0); set1(1, 0, 44, '0); #1;
        chk("ptr_reset_gnt0", cl.gnt0, 1);
        chk("ptr_reset_gnt1", cl.gnt1, 0);

`ifdef BLOCKRAM_CLEAR_ON_RESET_EN
        // Reset in the middle of a sweep restarts it from address 0.
        @(negedge clock); idle(); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        repeat (30) @(negedge clock);
        #1;
        chk("mid_addr30", mem_addr, 30);
        @(negedge clock); reset = 1'b1; #1;
        chk("mid_rst_we", mem_we, 0);
        @(negedge clock); reset = 1'b0; #1;
        chk("mid_restart_addr", mem_addr, 0);
        begin
            int n;
            n = 0;
            for (int k = 0; k < 100 && busy; k++) begin n++; @(negedge clock); #1; end
            chk("mid_sweep_len", n, MD);
        end
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/blockram_rr_arbiter.md
Name: blockram_rr_arbiter

Overview:
- Shares one single-port, synchronous-read block RAM (write-enable, 1-cycle read latency) between two requester ports.
- Uses round-robin arbitration with a per-port request/grant handshake and a per-port read-return valid.
- Optionally runs a clear sweep that writes a fixed value to every RAM word after reset, before any grants.
- Sits between the RAM instance and the two client engines that previously needed exclusive access.

Parameters:
- blockLength, 32, data width of the RAM word and of all data ports.
- memDepth, 64, number of RAM words; clear sweep length.
- addressBitWidth, 6, address width; memDepth <= 2**addressBitWidth.
- CLEAR_VALUE, 0, word written to every address during the clear sweep (blockLength bits).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  addressBitWidth  port 0 address.
- wdata0  in  blockLength  port 0 write data.
- gnt0  out  1  port 0 grant; request consumed in this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  blockLength  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  addressBitWidth  RAM address.
- mem_din  out  blockLength  RAM write data.
- mem_dout  in  blockLength  RAM read data, valid one clock after the address.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- One clock; reset is synchronous and active-high; port names are clock and reset.
- Reset, sampled at a clock edge:
  - priority pointer = port 0;
  - rvalid0 = rvalid1 = 0;
  - FSM goes to CLEAR (with macro) or ARB (without).
- While reset is high: gnt0 = gnt1 = 0 and mem_we = 0.
- FSM states:
  - CLEAR: busy = 1, gnt0 = gnt1 = 0, mem_we = 1, mem_addr = clr_cnt, mem_din = CLEAR_VALUE. clr_cnt counts 0 to memDepth-1, one address per cycle. At clr_cnt = memDepth-1, go to ARB next cycle. The sweep takes exactly memDepth cycles.
  - ARB: busy = 0. Combinational grant from req0/req1 and the pointer:
    - only one port requesting: that port is granted;
    - both requesting: the port not granted last time wins (pointer);
    - neither requesting: no grant, mem_we = 0.
- Pointer update: on each grant it moves to the other port. It is unchanged on idle cycles.
- Granted port drives the RAM in the same cycle: mem_we = weK, mem_addr = addrK, mem_din = wdataK. At most one gnt is high per cycle.
- Read return: a read granted in cycle N sets rvalidK = 1 in cycle N+1 only. rdataK = mem_dout, meaningful only while rvalidK = 1.
- Write grants produce no rvalid.
- Throughput: one access per cycle, back-to-back grants allowed, including the same port on consecutive cycles if the other port is idle.
- Fairness: a port holding req is granted within 2 cycles in ARB.
- Same-address read granted the cycle after a write returns the newly written data (RAM read-after-write).
- Mid-operation reset:
  - pending rvalid is dropped (rvalid = 0 next cycle);
  - a clear sweep in progress restarts at address 0;
  - the pointer returns to port 0.
- Requests asserted during CLEAR or reset are held off (no gnt) and served on entry to ARB.

Optional Feature:
- Macro: BLOCKRAM_CLEAR_ON_RESET_EN.
- Defined: CLEAR state present; every reset runs the memDepth-cycle sweep writing CLEAR_VALUE before the first grant.
- Undefined: no CLEAR state or counter; busy tied 0; arbitration starts the first cycle after reset deasserts; RAM keeps its init-file or prior contents.

Test Plan:
- Macro on, reset 1 cycle, memDepth = 64 → busy high 64 cycles, mem_we = 1 with addr 0..63 and din 0; gnt held 0 despite req0 = 1; gnt0 on the cycle busy falls.
- Port 0 writes 0xDEADBEEF to addr 5; next cycle port 0 reads addr 5 → rvalid0 exactly one cycle later, rdata0 = 0xDEADBEEF, rvalid1 stays 0.
- req0 and req1 held high for 6 cycles after reset → grants alternate 0,1,0,1,0,1; each read's rvalid lands on the correct port.
- Only req1 high for 4 cycles → gnt1 every cycle (back-to-back); then req0 rises → gnt0 next, since the pointer favours port 0.
- Reset asserted at clear address 30 → next cycle mem_addr = 0 again; the sweep completes 64 cycles after reset falls.
- Macro off → busy = 0; req0 read of addr 3 granted the first cycle after reset; rdata0 equals the init-file contents.
